// File: rtl/addr_seq_unlock_pkg.sv
// Shared types and helpers for the address-sequence unlock block.
// Holds the FSM state encoding, the bus window decode and key-step selection.
package addr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEQ      = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } state_t;

  localparam logic WIN_BA13 = 1'b0;
  localparam logic WIN_BA12 = 1'b1;

  // Returns key step k of a packed key whose steps are w bits wide.
  function automatic logic [7:0] key_sel(input logic [63:0] key,
                                         input int unsigned k,
                                         input int unsigned w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return 8'((key >> (k * w)) & mask);
  endfunction

endpackage

// File: rtl/addr_seq_unlock_if.sv
// Bus-side access signals observed by the unlock block.
// The block only listens; it never stalls the bus.
interface addr_seq_unlock_if;
  logic        access_stb;
  logic        sel_n;
  logic [13:0] ba;
  logic        br_w;

  modport master (output access_stb, sel_n, ba, br_w);
  modport slave  (input  access_stb, sel_n, ba, br_w);
endinterface

// File: rtl/addr_seq_unlock_seq_timer.sv
// Loadable down-counter: load to CYC, count to zero, pulse expire on the last tick.
// Latency: expire is combinational in the cycle whose edge would reach zero; no backpressure.
module seq_timer #(
  parameter int unsigned CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  output logic expire
);

  localparam int unsigned W = $clog2(CYC + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(CYC);
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // A reload in the expiry cycle wins, so the pulse is suppressed.
  assign expire = (cnt == W'(1)) && !load && !clr;

endmodule

// File: rtl/addr_seq_unlock.sv
// Unlocks on a nibble sequence of qualified reads, then shifts a board ID out on sdrd.
// Latency: all outputs registered, one clk after the qualifying strobe; passive listener, no backpressure.
module addr_seq_unlock
  import addr_seq_pkg::*;
#(
  parameter int unsigned           KEY_LEN     = 4,
  parameter int unsigned           KEY_W       = 4,
  parameter int unsigned           FIELD_LSB   = 4,
  parameter                        KEY         = 16'hA5C3,
  parameter logic [KEY_W-1:0]      RELOCK_CODE = 4'hF,
  parameter int unsigned           ID_W        = 8,
  parameter logic [ID_W-1:0]       ID          = 8'h36,
  parameter int unsigned           TIMEOUT_CYC = 1024,
  parameter int unsigned           MAX_FAIL    = 3,
  parameter int unsigned           LOCKOUT_CYC = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  addr_seq_unlock_if.slave             bus,
  output logic                         unlocked,
  output logic [$clog2(KEY_LEN+1)-1:0] step,
  output logic                         locked_out,
  output logic                         sdrd,
  output logic                         sdrd_oe
);

  localparam int unsigned STEP_W = $clog2(KEY_LEN + 1);
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int unsigned IDX_W  = $clog2(ID_W);

  if (KEY_LEN * KEY_W > $bits(KEY)) begin : g_key_chk
    $error("addr_seq_unlock: KEY_LEN*KEY_W exceeds width of KEY");
  end
  if (RELOCK_CODE == '0) begin : g_relock_chk
    $error("addr_seq_unlock: RELOCK_CODE must be nonzero");
  end
  if (KEY_LEN < 2 || KEY_LEN > 8 || ID_W < 2) begin : g_range_chk
    $error("addr_seq_unlock: KEY_LEN must be 2..8 and ID_W at least 2");
  end

  state_t              state;
  logic [FAIL_W-1:0]   fail_cnt;
  logic [IDX_W-1:0]    idx;

  logic                qual;
  logic [KEY_W-1:0]    field;
  logic [KEY_W-1:0]    key_exp;
  logic [KEY_W-1:0]    key0;
  logic                in_seq;
  logic                match;
  logic [FAIL_W-1:0]   fail_inc;
  logic                lock_hit;
  logic                seq_load, seq_clr, seq_exp;
  logic                lock_load, lock_clr, lock_exp;

  assign qual = bus.access_stb && !bus.sel_n && (bus.ba[13] == WIN_BA13) &&
                (bus.ba[12] == WIN_BA12) && bus.br_w;
  assign field    = bus.ba[FIELD_LSB +: KEY_W];
  assign key_exp  = KEY_W'(key_sel(64'(KEY), int'(step), KEY_W));
  assign key0     = KEY_W'(key_sel(64'(KEY), 0, KEY_W));
  assign in_seq   = (state == IDLE) || (state == SEQ);
  assign match    = (field == key_exp);
  assign fail_inc = fail_cnt + FAIL_W'(1);
  assign lock_hit = qual && in_seq && !match && (fail_inc == FAIL_W'(MAX_FAIL));

  // Every qualified access in the key phase restarts the idle window.
  assign seq_load  = qual && in_seq;
  assign seq_clr   = (state == UNLOCKED) || (state == LOCKOUT);
  assign lock_load = lock_hit;
  assign lock_clr  = (state != LOCKOUT) && !lock_hit;

  seq_timer #(.CYC(TIMEOUT_CYC)) u_seq_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (seq_load),
    .clr    (seq_clr),
    .expire (seq_exp)
  );

  seq_timer #(.CYC(LOCKOUT_CYC)) u_lock_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (lock_load),
    .clr    (lock_clr),
    .expire (lock_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      step       <= '0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      sdrd       <= 1'b0;
      sdrd_oe    <= 1'b0;
      fail_cnt   <= '0;
      idx        <= '0;
    end else begin
      sdrd_oe <= 1'b0;
      case (state)
        IDLE, SEQ: begin
          if (qual) begin
            if (match) begin
              if (step == STEP_W'(KEY_LEN - 1)) begin
                state    <= UNLOCKED;
                step     <= STEP_W'(KEY_LEN);
                unlocked <= 1'b1;
                fail_cnt <= '0;
              end else begin
                state <= SEQ;
                step  <= step + STEP_W'(1);
              end
            end else if (lock_hit) begin
              state      <= LOCKOUT;
              step       <= '0;
              locked_out <= 1'b1;
              fail_cnt   <= fail_inc;
            end else begin
              fail_cnt <= fail_inc;
              // A mismatching nibble may itself be the first key step.
              if (field == key0) begin
                state <= SEQ;
                step  <= STEP_W'(1);
              end else begin
                state <= IDLE;
                step  <= '0;
              end
            end
          end else if (state == SEQ && seq_exp) begin
            state <= IDLE;
            step  <= '0;
          end
        end
        UNLOCKED: begin
          if (qual) begin
            if (field == '0) begin
              sdrd    <= ID[idx];
              sdrd_oe <= 1'b1;
              idx     <= (idx == IDX_W'(ID_W - 1)) ? '0 : idx + IDX_W'(1);
            end else if (field == RELOCK_CODE) begin
              state    <= IDLE;
              step     <= '0;
              idx      <= '0;
              unlocked <= 1'b0;
            end
          end
        end
        LOCKOUT: begin
          if (lock_exp) begin
            state      <= IDLE;
            fail_cnt   <= '0;
            locked_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_seq_unlock.sv
// Directed bench for addr_seq_unlock: key entry, ID readout, relock, failures, lockout, timeout, reset.
module tb_addr_seq_unlock;

  logic       clk;
  logic       rst_n;
  logic       unlocked;
  logic [2:0] step;
  logic       locked_out;
  logic       sdrd;
  logic       sdrd_oe;

  int checks   = 0;
  int failures = 0;

  addr_seq_unlock_if bus ();

  addr_seq_unlock dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .unlocked   (unlocked),
    .step       (step),
    .locked_out (locked_out),
    .sdrd       (sdrd),
    .sdrd_oe    (sdrd_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns on the falling edge right after the sampling edge.
  task automatic access(input logic [3:0] f, input logic sn = 1'b0,
                        input logic b13 = 1'b0, input logic rw = 1'b1);
    @(negedge clk);
    bus.ba         = {b13, 1'b1, 4'h0, f, 4'h0};
    bus.sel_n      = sn;
    bus.br_w       = rw;
    bus.access_stb = 1'b1;
    @(negedge clk);
    bus.access_stb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic enter_key();
    access(4'h3);
    access(4'hC);
    access(4'h5);
    access(4'hA);
  endtask

  int sd_exp [9] = '{0, 1, 1, 0, 1, 1, 0, 0, 0};

  initial begin
    rst_n          = 1'b0;
    bus.access_stb = 1'b0;
    bus.sel_n      = 1'b1;
    bus.ba         = '0;
    bus.br_w       = 1'b0;
    #12;
    chk("rst_unlocked", unlocked, 0);
    chk("rst_step", step, 0);
    chk("rst_locked", locked_out, 0);
    chk("rst_sdrd", sdrd, 0);
    chk("rst_sdrd_oe", sdrd_oe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Correct key, step-by-step
    access(4'h3); chk("key_step1", step, 1); chk("key_unl1", unlocked, 0);
    access(4'hC); chk("key_step2", step, 2);
    access(4'h5); chk("key_step3", step, 3); chk("key_unl3", unlocked, 0);
    access(4'hA); chk("key_step4", step, 4); chk("key_unl4", unlocked, 1);

    // ID readout, LSB first, wrapping after 8 bits
    for (int i = 0; i < 9; i++) begin
      access(4'h0);
      chk($sformatf("id_oe%0d", i), sdrd_oe, 1);
      chk($sformatf("id_bit%0d", i), sdrd, sd_exp[i]);
    end
    idle(1);
    chk("id_oe_drop", sdrd_oe, 0);
    chk("id_hold", sdrd, 0);
    access(4'h7);
    chk("unl_ignore", unlocked, 1);
    chk("unl_ignore_oe", sdrd_oe, 0);

    // Relock
    access(4'hF);
    chk("relock_unl", unlocked, 0);
    chk("relock_step", step, 0);

    // Mismatches: 3,C,3 restarts at 1; 7 drops to 0; 9 is the third failure
    access(4'h3); chk("mm_step1", step, 1);
    access(4'hC); chk("mm_step2", step, 2);
    access(4'h3); chk("mm_restart", step, 1);
    access(4'h7); chk("mm_zero", step, 0); chk("mm_notlocked", locked_out, 0);
    access(4'h9); chk("lock_on", locked_out, 1); chk("lock_step", step, 0);

    // Key ignored during lockout; lockout lasts exactly 4096 cycles
    enter_key();
    chk("lock_key_unl", unlocked, 0);
    chk("lock_key_step", step, 0);
    idle(4096 - 8 - 1);
    chk("lock_last", locked_out, 1);
    idle(1);
    chk("lock_off", locked_out, 0);
    enter_key();
    chk("post_lock_unl", unlocked, 1);
    access(4'hF);
    chk("post_lock_relock", unlocked, 0);

    // Idle timeout: 1023 idle cycles keep progress, 1024 abort it
    access(4'h3);
    access(4'hC);
    idle(1023);
    chk("to_before", step, 2);
    idle(1);
    chk("to_after", step, 0);
    chk("to_nolock", locked_out, 0);
    chk("to_unl", unlocked, 0);
    enter_key();
    chk("to_rekey", unlocked, 1);
    access(4'hF);

    // Access landing exactly in the expiry cycle wins over the timeout
    access(4'h3);
    access(4'hC);
    idle(1022);
    access(4'h5);
    chk("to_prio_step", step, 3);
    access(4'hA);
    chk("to_prio_unl", unlocked, 1);
    access(4'hF);

    // Non-qualified accesses with a correct field
    access(4'h3, 1'b1, 1'b0, 1'b1); chk("nq_sel", step, 0);
    access(4'h3, 1'b0, 1'b1, 1'b1); chk("nq_ba13", step, 0);
    access(4'h3, 1'b0, 1'b0, 1'b0); chk("nq_write", step, 0);
    chk("nq_unl", unlocked, 0);

    // Asynchronous reset mid-sequence
    access(4'h3);
    access(4'hC);
    access(4'h5);
    chk("ar_pre", step, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_step", step, 0);
    chk("ar_unl", unlocked, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-ID, with sdrd high
    enter_key();
    access(4'h0);
    access(4'h0);
    chk("ar2_sdrd_pre", sdrd, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar2_sdrd", sdrd, 0);
    chk("ar2_oe", sdrd_oe, 0);
    chk("ar2_unl", unlocked, 0);
    chk("ar2_step", step, 0);
    @(negedge clk);
    rst_n = 1'b1;
    access(4'hC);
    chk("ar2_fresh", step, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
